// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types, prescale constants and legality check for the UART RX controller.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    APPLY,
    ACK_WAIT
  } ctrl_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Error flags carried alongside a received byte, {stop,par}.
  typedef struct packed {
    logic stop;
    logic par;
  } rx_err_t;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a head read straight from the storage registers.
// Latency: a pushed entry is visible at the head the cycle after the push; no bypass.
// Backpressure: pop is ignored when empty; push is ignored when full unless a pop frees a slot.
module uart_rx_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same slot index with differing wrap bits means every entry is occupied.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are only observed while the FIFO is non-empty, so no reset.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: applies PAR_EN/Prescale only between frames, buffers bytes, counts errors.
// Latency: out_valid rises 1 cycle after a push; cfg_ack comes 1 cycle after rx_busy is seen low in DRAIN.
// Backpressure: out_ready stalls the head; a push into a full FIFO without a pop is dropped and counted.
// Option UART_RX_CTRL_ERR_FRAME_EN: errored frames are also queued, with {stop,par} on out_err.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8,
  parameter int DEF_PRESCALE = 8,
  parameter int DEF_PAR_EN   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cfg_req,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  input  logic                  rx_busy,
  input  logic                  rx_data_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stop_err,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  output logic                  rx_en,
  output logic                  PAR_EN,
  output logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef UART_RX_CTRL_ERR_FRAME_EN
  output logic [1:0]            out_err,
`endif
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      par_err_cnt,
  output logic [CNT_W-1:0]      stop_err_cnt,
  output logic [CNT_W-1:0]      ovf_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  logic        cfg_load;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        drop;

`ifdef UART_RX_CTRL_ERR_FRAME_EN
  localparam int ENTRY_W = DATA_WIDTH + 2;
  rx_err_t              err_in;
  logic [ENTRY_W-1:0]   push_dat;
  logic [ENTRY_W-1:0]   head_dat;
  assign err_in.stop = rx_stop_err;
  assign err_in.par  = rx_par_err;
  assign push        = rx_data_valid | rx_par_err | rx_stop_err;
  assign push_dat    = {err_in, rx_p_data};
  assign out_data    = head_dat[DATA_WIDTH-1:0];
  assign out_err     = head_dat[ENTRY_W-1:DATA_WIDTH];
`else
  localparam int ENTRY_W = DATA_WIDTH;
  logic [ENTRY_W-1:0]   push_dat;
  logic [ENTRY_W-1:0]   head_dat;
  assign push        = rx_data_valid;
  assign push_dat    = rx_p_data;
  assign out_data    = head_dat;
`endif

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & ~pop;

  uart_rx_ctrl_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= RUN;
    else      state <= state_nxt;
  end

  // Next state plus ack/err; a request is latched once and not re-applied until cfg_req drops.
  always_comb begin
    state_nxt = state;
    cfg_ack   = 1'b0;
    cfg_err   = 1'b0;
    cfg_load  = 1'b0;
    case (state)
      RUN:      if (cfg_req) state_nxt = DRAIN;
      DRAIN:    if (!rx_busy) state_nxt = APPLY;
      APPLY: begin
        cfg_ack   = 1'b1;
        cfg_err   = ~is_legal_prescale(cfg_prescale);
        cfg_load  = is_legal_prescale(cfg_prescale);
        state_nxt = ACK_WAIT;
      end
      ACK_WAIT: if (!cfg_req) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Registered start-detect enable: low while waiting for the RX path to idle and while applying.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rx_en <= 1'b1;
    else      rx_en <= (state_nxt == RUN) || (state_nxt == ACK_WAIT);
  end

  // Applied configuration; only a legal request in APPLY changes it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Prescale <= 6'(DEF_PRESCALE);
      PAR_EN   <= 1'(DEF_PAR_EN);
    end else if (cfg_load) begin
      Prescale <= cfg_prescale;
      PAR_EN   <= cfg_par_en;
    end
  end

  // Saturating error/overflow counters; clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
      ovf_cnt      <= '0;
    end else if (clr_cnt) begin
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
      ovf_cnt      <= '0;
    end else begin
      if (rx_par_err && (par_err_cnt != CNT_MAX))   par_err_cnt  <= par_err_cnt + CNT_ONE;
      if (rx_stop_err && (stop_err_cnt != CNT_MAX)) stop_err_cnt <= stop_err_cnt + CNT_ONE;
      if (drop && (ovf_cnt != CNT_MAX))             ovf_cnt      <= ovf_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized and directed checks of uart_rx_ctrl against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST;
  logic       cfg_req;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_ack;
  logic       cfg_err;
  logic       rx_busy;
  logic       rx_data_valid;
  logic       rx_par_err;
  logic       rx_stop_err;
  logic [7:0] rx_p_data;
  logic       rx_en;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       clr_cnt;
  logic [7:0] par_err_cnt;
  logic [7:0] stop_err_cnt;
  logic [7:0] ovf_cnt;
`ifdef UART_RX_CTRL_ERR_FRAME_EN
  logic [1:0] out_err;
`endif

  uart_rx_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .cfg_req       (cfg_req),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_ack       (cfg_ack),
    .cfg_err       (cfg_err),
    .rx_busy       (rx_busy),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_stop_err   (rx_stop_err),
    .rx_p_data     (rx_p_data),
    .rx_en         (rx_en),
    .PAR_EN        (PAR_EN),
    .Prescale      (Prescale),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
`ifdef UART_RX_CTRL_ERR_FRAME_EN
    .out_err       (out_err),
`endif
    .clr_cnt       (clr_cnt),
    .par_err_cnt   (par_err_cnt),
    .stop_err_cnt  (stop_err_cnt),
    .ovf_cnt       (ovf_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } ent_t;

  ent_t       q[$];
  int         m_par;
  int         m_stop;
  int         m_ovf;
  logic [5:0] m_presc;
  logic       m_pe;
  int         vectors;
  int         miscompares;
  bit         rand_traffic;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue of DEPTH entries, counters as saturating integers.
  task automatic model_update();
    bit   pop;
    bit   push;
    bit   drop;
    ent_t e;
    pop = out_ready && (q.size() != 0);
`ifdef UART_RX_CTRL_ERR_FRAME_EN
    push  = rx_data_valid || rx_par_err || rx_stop_err;
    e.err = {rx_stop_err, rx_par_err};
`else
    push  = rx_data_valid;
    e.err = 2'b00;
`endif
    e.data = rx_p_data;
    drop = push && !pop && (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(e);
    if (clr_cnt) begin
      m_par = 0; m_stop = 0; m_ovf = 0;
    end else begin
      if (rx_par_err && m_par < 255) m_par++;
      if (rx_stop_err && m_stop < 255) m_stop++;
      if (drop && m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic model_check();
    check_val("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_val("out_data", 32'(out_data), 32'(q[0].data));
`ifdef UART_RX_CTRL_ERR_FRAME_EN
      check_val("out_err", 32'(out_err), 32'(q[0].err));
`endif
    end
    check_val("par_err_cnt", 32'(par_err_cnt), 32'(m_par));
    check_val("stop_err_cnt", 32'(stop_err_cnt), 32'(m_stop));
    check_val("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
  endtask

  // One clock: inputs are set at the falling edge, outputs are checked at the next falling edge.
  task automatic step();
    if (rand_traffic) begin
      rx_data_valid = ($urandom_range(0, 2) == 0);
      rx_p_data     = 8'($urandom);
      rx_par_err    = ($urandom_range(0, 7) == 0);
      rx_stop_err   = ($urandom_range(0, 7) == 0);
      out_ready     = 1'($urandom);
      clr_cnt       = ($urandom_range(0, 60) == 0);
    end
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    model_check();
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    cfg_req = 1'b0; cfg_prescale = 6'd0; cfg_par_en = 1'b0; rx_busy = 1'b0;
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stop_err = 1'b0; rx_p_data = 8'h00;
    out_ready = 1'b0; clr_cnt = 1'b0;
    q.delete(); m_par = 0; m_stop = 0; m_ovf = 0; m_presc = 6'd8; m_pe = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("rst_rx_en", 32'(rx_en), 32'd1);
    check_val("rst_par_en", 32'(PAR_EN), 32'd1);
    check_val("rst_prescale", 32'(Prescale), 32'd8);
    check_val("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    RST = 1'b1;
  endtask

  // Issue a config request with rx_busy held for nbusy cycles; check ack timing and result.
  task automatic do_cfg(input logic [5:0] p, input logic pe, input int nbusy);
    int cyc;
    bit legal;
    bit got_ack;
    legal = (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
    cfg_prescale = p; cfg_par_en = pe; cfg_req = 1'b1; rx_busy = (nbusy > 0);
    cyc = 0; got_ack = 0;
    while (!got_ack && cyc < 200) begin
      step();
      cyc++;
      if (cyc == 1) check_val("rx_en_drain", 32'(rx_en), 32'd0);
      if (cfg_ack) got_ack = 1;
      else if (cyc >= nbusy) rx_busy = 1'b0;
    end
    check_val("ack_latency", 32'(cyc), 32'((nbusy > 1 ? nbusy : 1) + 1));
    check_val("cfg_err", 32'(cfg_err), 32'(!legal));
    check_val("presc_during_ack", 32'(Prescale), 32'(m_presc));
    if (legal) begin
      m_presc = p; m_pe = pe;
    end
    repeat (2) begin
      step();
      check_val("ack_once", 32'(cfg_ack), 32'd0);
      check_val("rx_en_ackwait", 32'(rx_en), 32'd1);
    end
    check_val("prescale_applied", 32'(Prescale), 32'(m_presc));
    check_val("par_en_applied", 32'(PAR_EN), 32'(m_pe));
    cfg_req = 1'b0;
    repeat (2) step();
    check_val("rx_en_run", 32'(rx_en), 32'd1);
  endtask

  initial begin
    logic [7:0] frames [3];
    logic [7:0] saved [6];
    logic [7:0] extra;
    logic [5:0] choices [6];
    vectors = 0; miscompares = 0; rand_traffic = 0;
    frames[0] = 8'hA5; frames[1] = 8'h3C; frames[2] = 8'h0F;
    choices[0] = 6'd8; choices[1] = 6'd16; choices[2] = 6'd32;
    choices[3] = 6'd12; choices[4] = 6'd0; choices[5] = 6'd63;

    // Three frames stream through with out_ready held high.
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data_valid = 1'b1; rx_p_data = frames[i];
      step();
      check_val("t1_valid", 32'(out_valid), 32'd1);
      check_val("t1_data", 32'(out_data), 32'(frames[i]));
    end
    rx_data_valid = 1'b0;
    step();
    check_val("t1_empty", 32'(out_valid), 32'd0);

    // Illegal prescale rejected, then a legal one applied behind a 40-cycle busy frame.
    do_cfg(6'd12, 1'b0, 0);
    check_val("t3_prescale", 32'(Prescale), 32'd8);
    check_val("t3_par_en", 32'(PAR_EN), 32'd1);
    do_cfg(6'd16, 1'b0, 40);
    check_val("t2_prescale", 32'(Prescale), 32'd16);
    check_val("t2_par_en", 32'(PAR_EN), 32'd0);

    // Reset while draining drops the request, restores defaults and flushes the FIFO.
    out_ready = 1'b0;
    rx_data_valid = 1'b1; rx_p_data = 8'h11; step();
    rx_p_data = 8'h22; step();
    rx_data_valid = 1'b0;
    cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_req = 1'b1; rx_busy = 1'b1;
    repeat (3) step();
    apply_reset();
    repeat (3) begin
      step();
      check_val("rst_no_ack", 32'(cfg_ack), 32'd0);
    end

    // Overflow: six frames into a stalled depth-4 FIFO, then push and pop while full.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      saved[i] = 8'($urandom);
      rx_data_valid = 1'b1; rx_p_data = saved[i];
      step();
    end
    rx_data_valid = 1'b0;
    check_val("t4_valid", 32'(out_valid), 32'd1);
    check_val("t4_ovf", 32'(ovf_cnt), 32'd2);
    check_val("t4_head", 32'(out_data), 32'(saved[0]));
    extra = 8'($urandom);
    rx_data_valid = 1'b1; rx_p_data = extra; out_ready = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check_val("t4_no_drop", 32'(ovf_cnt), 32'd2);
    for (int i = 1; i < 4; i++) begin
      check_val("t4_order", 32'(out_data), 32'(saved[i]));
      step();
    end
    check_val("t4_last", 32'(out_data), 32'(extra));
    step();
    check_val("t4_drained", 32'(out_valid), 32'd0);

    // Counter saturation, dual increment, clear priority.
    apply_reset();
    out_ready = 1'b1;
    rx_par_err = 1'b1;
    repeat (300) step();
    check_val("t5_par_sat", 32'(par_err_cnt), 32'd255);
    rx_stop_err = 1'b1;
    step();
    check_val("t5_both_par", 32'(par_err_cnt), 32'd255);
    check_val("t5_both_stop", 32'(stop_err_cnt), 32'd1);
    rx_stop_err = 1'b0; clr_cnt = 1'b1;
    step();
    check_val("t5_clr", 32'(par_err_cnt), 32'd0);
    rx_par_err = 1'b0; clr_cnt = 1'b0;
    step();

`ifdef UART_RX_CTRL_ERR_FRAME_EN
    // Errored frame is queued with its flags.
    apply_reset();
    rx_stop_err = 1'b1; rx_p_data = 8'h55;
    step();
    rx_stop_err = 1'b0;
    check_val("t6_data", 32'(out_data), 32'h55);
    check_val("t6_err", 32'(out_err), 32'd2);
    check_val("t6_stop_cnt", 32'(stop_err_cnt), 32'd1);
`endif

    // Random traffic with config requests interleaved.
    apply_reset();
    rand_traffic = 1;
    for (int r = 0; r < 6; r++) begin
      repeat (300) step();
      do_cfg(choices[$urandom_range(0, 5)], 1'($urandom), int'($urandom_range(0, 6)));
    end
    rand_traffic = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
